bsg_unswap_fifo: RTL and testbench
==================================

Name: bsg_unswap_fifo

Overview:
- Receive-side counterpart of the half-word lane swapper: it takes 2*width_p words that may arrive half-swapped, with a per-word swap_i tag.
- Restores canonical lane order by undoing the swap when swap_i=1.
- Buffers the restored words in a small FIFO with valid/ready input and valid/yumi output handshakes.
- Sits at the consumer end of a swapped datapath, decoupling the producer from downstream backpressure.

Parameters:
- width_p, 32, half-word width; data words are 2*width_p bits.
- els_p, 4, FIFO depth; power of 2, >= 2.
- lg_els_lp, $clog2(els_p), pointer width (localparam).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- v_i  input  1  input word valid.
- data_i  input  2*width_p  input word, possibly lane-swapped.
- swap_i  input  1  1 = data_i arrived with halves exchanged.
- ready_o  output  1  FIFO can accept a word this cycle.
- v_o  output  1  head entry valid.
- data_o  output  2*width_p  head word in canonical lane order.
- swap_o  output  1  swap_i tag recorded with the head word.
- yumi_i  input  1  consumer takes the head word this cycle.
- count_o  output  lg_els_lp+1  current occupancy, 0..els_p.

Behaviour:
- Reset: asynchronous, active-high. On assertion, immediately:
  - clear read pointer, write pointer and count;
  - v_o=0, count_o=0, ready_o=1;
  - data_o=0 and swap_o=0 (forced while empty).
  - Storage array is not reset.
  - Asserting reset mid-transfer discards all buffered words; no partial state survives.
- Enqueue fires when v_i & ready_o.
  - Stored word = swap_i ? {data_i[width_p-1:0], data_i[2*width_p-1:width_p]} : data_i.
  - swap_i is stored alongside the word.
  - The lane restore is combinational, before the write.
- ready_o = (count != els_p). It depends only on registered state, not on yumi_i, so a full FIFO does not accept a word in a cycle where a yumi occurs.
- v_o = (count != 0). data_o and swap_o show the head entry when v_o=1, and are forced to 0 when v_o=0.
- Latency: a word enqueued at edge N is visible on v_o/data_o after edge N (zero-cycle bypass is not provided).
- Dequeue fires when yumi_i & v_o; the read pointer advances at the edge. yumi_i while v_o=0 is a protocol violation: ignore it, leave state unchanged, and flag it with a simulation assertion.
- Simultaneous enqueue and dequeue (count in 1..els_p-1): both occur, count unchanged, both pointers advance.
- Full: ready_o=0; v_i is ignored with no state change. Empty: v_o=0; yumi_i is ignored.
- Pointers are lg_els_lp bits and wrap naturally from els_p-1 to 0. count is a separate lg_els_lp+1-bit counter: +1 on enqueue only, -1 on dequeue only.
- v_i, data_i and swap_i have no effect when the enqueue does not fire.

Decomposition:
- Shared package (bsg_unswap_pkg): the half-word swap helper function, used by this block and by the bench scoreboard.
- Sub-module bsg_unswap_mem: els_p x (2*width_p+1) register file with one synchronous write port, one asynchronous read port, and no reset. The pointer, count and handshake logic stays in bsg_unswap_fifo.

Test Plan (width_p=32, els_p=4):
1. Reset, then enqueue data_i=64'h11112222_33334444 with swap_i=1 -> next cycle v_o=1, data_o=64'h33334444_11112222, swap_o=1, count_o=1.
2. Enqueue 4 words with swap_i=0 and no yumi -> count_o=4, ready_o=0. A fifth v_i is dropped. Then 4 yumis return the words in order and count_o returns to 0.
3. At count 2, hold v_i=1 and yumi_i=1 together for 6 cycles -> count_o stays 2, output order matches input order, and pointers wrap past 3 to 0 correctly.
4. Full FIFO, v_i=1 and yumi_i=1 in the same cycle -> only the dequeue occurs, count_o goes 4 to 3, and the incoming word is not stored.
5. Assert reset_i asynchronously between edges with count 3 -> v_o=0, count_o=0, data_o=0 immediately. After release, the first enqueued word appears alone at the head.
6. Empty FIFO, yumi_i=1 -> no state change, count_o=0, and the assertion fires.

Source files
------------

// File: rtl/bsg_unswap_pkg.sv
// bsg_unswap_pkg: definitions shared by the unswap FIFO and its bench.
//
// Contents:
//   max_width_lp - largest supported half-word width.
//   word_t       - container wide enough for any 2*width word.
//   half_swap()  - exchanges the two width-bit halves of a 2*width-bit word
//                  held in the low bits of a word_t. Bits above 2*width are
//                  returned as zero.
package bsg_unswap_pkg;

  localparam int unsigned max_width_lp = 256;

  typedef logic [2*max_width_lp-1:0] word_t;

  // Rotating a 2w-bit word by w bits is the same as exchanging its halves.
  // The mask drops whatever the left shift pushed above bit 2w-1. At
  // w == max_width_lp the mask shift overflows to zero and the subtraction
  // wraps to all ones, which is the right mask for that case.
  function automatic word_t half_swap(input word_t d, input int unsigned w);
    word_t mask;
    mask = (word_t'(1) << (2*w)) - word_t'(1);
    return ((d >> w) | (d << w)) & mask;
  endfunction

endpackage

// File: rtl/bsg_unswap_fifo_if.sv
// bsg_unswap_fifo_if: bundle of the FIFO's handshake and data signals.
//
// Handshakes:
//   enq side: a word transfers on a rising edge where enq_v & enq_ready.
//             enq_ready is registered state only; it never looks at deq_yumi.
//   deq side: deq_v/deq_data/deq_swap show the head word. The consumer
//             raises deq_yumi to take it and may do so only while deq_v = 1.
//
// Modports:
//   master - the environment: drives enq_v/enq_data/enq_swap and deq_yumi.
//   slave  - the FIFO: drives enq_ready, deq_v/deq_data/deq_swap and count.
interface bsg_unswap_fifo_if #(
  parameter int width_p = 32,
  parameter int els_p   = 4
);
  localparam int lg_els_lp = $clog2(els_p);

  logic                 enq_v;
  logic [2*width_p-1:0] enq_data;
  logic                 enq_swap;
  logic                 enq_ready;
  logic                 deq_v;
  logic [2*width_p-1:0] deq_data;
  logic                 deq_swap;
  logic                 deq_yumi;
  logic [lg_els_lp:0]   count;

  modport master (
    output enq_v, enq_data, enq_swap, deq_yumi,
    input  enq_ready, deq_v, deq_data, deq_swap, count
  );

  modport slave (
    input  enq_v, enq_data, enq_swap, deq_yumi,
    output enq_ready, deq_v, deq_data, deq_swap, count
  );

endinterface

// File: rtl/bsg_unswap_mem.sv
// bsg_unswap_mem: els_p x width_p register file for the unswap FIFO.
//
// One synchronous write port and one asynchronous read port. The array is
// not reset; the FIFO never shows an entry it has not written.
//
// Ports:
//   clk_i    - write clock
//   w_v_i    - write enable
//   w_addr_i - write address
//   w_data_i - write data
//   r_addr_i - read address
//   r_data_o - read data (combinational from r_addr_i)
module bsg_unswap_mem #(
  parameter int width_p = 65,
  parameter int els_p   = 4,
  localparam int lg_els_lp = $clog2(els_p)
) (
  input  logic                 clk_i,
  input  logic                 w_v_i,
  input  logic [lg_els_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]   w_data_i,
  input  logic [lg_els_lp-1:0] r_addr_i,
  output logic [width_p-1:0]   r_data_o
);

  logic [width_p-1:0] mem_r [els_p];

  always_ff @(posedge clk_i) begin
    if (w_v_i) begin
      mem_r[w_addr_i] <= w_data_i;
    end
  end

  assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/bsg_unswap_fifo.sv
// bsg_unswap_fifo: restores canonical lane order of possibly half-swapped
// 2*width_p-bit words and buffers them in an els_p-deep FIFO.
//
// Ports:
//   clk_i   - clock, all state changes on the rising edge
//   reset_i - asynchronous active-high reset; clears pointers and count
//   v_i     - input word valid
//   data_i  - input word, halves exchanged when swap_i = 1
//   swap_i  - swap tag, stored with the word
//   ready_o - FIFO can take a word (count != els_p)
//   v_o     - head entry valid (count != 0)
//   data_o  - head word in canonical lane order, 0 while empty
//   swap_o  - swap tag of the head word, 0 while empty
//   yumi_i  - consumer takes the head word; only legal while v_o = 1
//   count_o - current occupancy, 0..els_p
//
// Handshakes: enqueue fires on v_i & ready_o, dequeue on yumi_i & v_o.
// ready_o depends only on registered state, so a full FIFO refuses a word
// even in a cycle where the head is being taken. A written word is visible
// at the head only after the edge that stores it.
module bsg_unswap_fifo
  import bsg_unswap_pkg::*;
#(
  parameter int width_p = 32,
  parameter int els_p   = 4,
  localparam int lg_els_lp = $clog2(els_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 v_i,
  input  logic [2*width_p-1:0] data_i,
  input  logic                 swap_i,
  output logic                 ready_o,
  output logic                 v_o,
  output logic [2*width_p-1:0] data_o,
  output logic                 swap_o,
  input  logic                 yumi_i,
  output logic [lg_els_lp:0]   count_o
);

  localparam int entry_w_lp = 2*width_p + 1;

  logic [lg_els_lp-1:0] rd_ptr_r;
  logic [lg_els_lp-1:0] wr_ptr_r;
  logic [lg_els_lp:0]   count_r;

  logic enq;
  logic deq;

  word_t                 swapped_full;
  logic [2*width_p-1:0]  restored;
  logic [entry_w_lp-1:0] w_entry;
  logic [entry_w_lp-1:0] r_entry;

  assign ready_o = (count_r != (lg_els_lp+1)'(els_p));
  assign v_o     = (count_r != '0);

  assign enq = v_i & ready_o;
  // A yumi while empty is dropped here so it cannot move the read pointer.
  assign deq = yumi_i & v_o;

  // Lane restore happens before the write, so storage holds canonical words.
  assign swapped_full = half_swap(word_t'(data_i), width_p);
  assign restored     = swap_i ? swapped_full[2*width_p-1:0] : data_i;
  assign w_entry      = {swap_i, restored};

  bsg_unswap_mem #(
    .width_p (entry_w_lp),
    .els_p   (els_p)
  ) mem (
    .clk_i    (clk_i),
    .w_v_i    (enq),
    .w_addr_i (wr_ptr_r),
    .w_data_i (w_entry),
    .r_addr_i (rd_ptr_r),
    .r_data_o (r_entry)
  );

  // Pointers wrap naturally at els_p because els_p is a power of two.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (enq) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (deq) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      if (enq && !deq) begin
        count_r <= count_r + 1'b1;
      end else if (deq && !enq) begin
        count_r <= count_r - 1'b1;
      end
    end
  end

  // Unwritten or stale storage is never exposed: outputs are forced to zero
  // whenever the FIFO is empty, including straight out of reset.
  assign data_o  = v_o ? r_entry[2*width_p-1:0] : '0;
  assign swap_o  = v_o ? r_entry[2*width_p]     : 1'b0;
  assign count_o = count_r;

  // A consumer that takes from an empty FIFO is broken; the word is ignored
  // in hardware but flagged in simulation.
  yumi_while_empty: assert property (
    @(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o)
  ) else $warning("bsg_unswap_fifo: yumi_i asserted while empty, ignored");

endmodule

// File: tb/tb_bsg_unswap_fifo.sv
// tb_bsg_unswap_fifo: self-checking bench for bsg_unswap_fifo.
//
// A queue model holds the words the FIFO must contain; every negative edge
// the DUT outputs are compared against the model, and a few literal values
// pin the model itself.
module tb_bsg_unswap_fifo;

  localparam int W = 32;
  localparam int E = 4;
  localparam int DW = 2*W;

  logic clk_i = 1'b0;
  logic reset_i;

  bsg_unswap_fifo_if #(.width_p(W), .els_p(E)) bus ();

  bsg_unswap_fifo #(.width_p(W), .els_p(E)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (bus.enq_v),
    .data_i  (bus.enq_data),
    .swap_i  (bus.enq_swap),
    .ready_o (bus.enq_ready),
    .v_o     (bus.deq_v),
    .data_o  (bus.deq_data),
    .swap_o  (bus.deq_swap),
    .yumi_i  (bus.deq_yumi),
    .count_o (bus.count)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // scoreboard: entry = {swap, canonical word}
  logic [DW:0] exp_q[$];

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: what the FIFO must hold after each edge, computed from the
  // occupancy rules alone.
  always @(posedge clk_i or posedge reset_i) begin
    bit do_enq, do_deq;
    logic [DW-1:0] d;
    if (reset_i) begin
      exp_q.delete();
    end else begin
      do_deq = bus.deq_yumi && (exp_q.size() != 0);
      do_enq = bus.enq_v && (exp_q.size() != E);
      d = bus.enq_data;
      if (do_deq) void'(exp_q.pop_front());
      if (do_enq)
        exp_q.push_back({bus.enq_swap, bus.enq_swap ? {d[W-1:0], d[DW-1:W]} : d});
    end
  end

  // Compare process: outputs depend on registered state only, so sampling
  // at the negative edge is race free.
  always @(negedge clk_i) begin
    logic [DW:0] head;
    bit ev;
    if (check_en && !reset_i) begin
      ev = (exp_q.size() != 0);
      head = ev ? exp_q[0] : '0;
      chk("count_o", DW'(bus.count), DW'(exp_q.size()));
      chk("v_o", DW'(bus.deq_v), DW'(ev));
      chk("ready_o", DW'(bus.enq_ready), DW'(exp_q.size() != E));
      chk("data_o", bus.deq_data, head[DW-1:0]);
      chk("swap_o", DW'(bus.deq_swap), DW'(head[DW]));
    end
  end

  // driver: one cycle of stimulus, inputs return to idle afterwards
  task automatic step(input bit v, input logic [DW-1:0] d, input bit s,
                      input bit y);
    @(negedge clk_i);
    #1;
    bus.enq_v = v;
    bus.enq_data = d;
    bus.enq_swap = s;
    bus.deq_yumi = y;
    @(posedge clk_i);
    #1;
    bus.enq_v = 1'b0;
    bus.enq_data = '0;
    bus.enq_swap = 1'b0;
    bus.deq_yumi = 1'b0;
  endtask

  initial begin
    bus.enq_v = 1'b0;
    bus.enq_data = '0;
    bus.enq_swap = 1'b0;
    bus.deq_yumi = 1'b0;
    reset_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    chk("reset count_o", DW'(bus.count), '0);
    chk("reset v_o", DW'(bus.deq_v), '0);
    chk("reset ready_o", DW'(bus.enq_ready), DW'(1));
    chk("reset data_o", bus.deq_data, '0);
    #1;
    reset_i = 1'b0;
    check_en = 1'b1;

    // 1: swapped word is restored
    step(1'b1, 64'h11112222_33334444, 1'b1, 1'b0);
    chk("t1 data_o", bus.deq_data, 64'h33334444_11112222);
    chk("t1 swap_o", DW'(bus.deq_swap), DW'(1));
    chk("t1 count_o", DW'(bus.count), DW'(1));
    step(1'b0, '0, 1'b0, 1'b1);

    // 2: fill, overflow attempt dropped, drain in order
    for (int i = 0; i < E; i++) step(1'b1, 64'hA000_0000_0000_0000 + 64'(i), 1'b0, 1'b0);
    chk("t2 count full", DW'(bus.count), DW'(4));
    chk("t2 ready full", DW'(bus.enq_ready), '0);
    step(1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 1'b0);
    for (int i = 0; i < E; i++) begin
      chk("t2 drain data", bus.deq_data, 64'hA000_0000_0000_0000 + 64'(i));
      step(1'b0, '0, 1'b0, 1'b1);
    end
    chk("t2 count empty", DW'(bus.count), '0);

    // 3: steady state at count 2 with simultaneous enqueue/dequeue
    step(1'b1, 64'h0000_0001_0000_0002, 1'b1, 1'b0);
    step(1'b1, 64'h0000_0003_0000_0004, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 64'hB0 + 64'(i), i[0], 1'b1);
    chk("t3 count", DW'(bus.count), DW'(2));

    // 4: full, yumi and v_i together: only the dequeue happens
    step(1'b1, 64'hC1, 1'b0, 1'b0);
    step(1'b1, 64'hC2, 1'b0, 1'b0);
    chk("t4 count full", DW'(bus.count), DW'(4));
    step(1'b1, 64'hC3, 1'b0, 1'b1);
    chk("t4 count after", DW'(bus.count), DW'(3));
    repeat (3) step(1'b0, '0, 1'b0, 1'b1);

    // 5: asynchronous reset with three words buffered
    for (int i = 0; i < 3; i++) step(1'b1, 64'hD0 + 64'(i), 1'b0, 1'b0);
    #1;
    reset_i = 1'b1;
    #1;
    chk("t5 async v_o", DW'(bus.deq_v), '0);
    chk("t5 async count_o", DW'(bus.count), '0);
    chk("t5 async data_o", bus.deq_data, '0);
    @(negedge clk_i);
    #2;
    reset_i = 1'b0;
    step(1'b1, 64'hE0E0_E0E0_0F0F_0F0F, 1'b1, 1'b0);
    chk("t5 head data", bus.deq_data, 64'h0F0F_0F0F_E0E0_E0E0);
    chk("t5 head count", DW'(bus.count), DW'(1));
    step(1'b0, '0, 1'b0, 1'b1);

    // 6: yumi on an empty FIFO is ignored
    step(1'b0, '0, 1'b0, 1'b1);
    chk("t6 count", DW'(bus.count), '0);
    chk("t6 v_o", DW'(bus.deq_v), '0);

    // random traffic; yumi only while the model says the head is valid
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 1) == 1, {$urandom(), $urandom()},
           $urandom_range(0, 1) == 1,
           ($urandom_range(0, 2) != 0) && (exp_q.size() != 0));
    end

    repeat (2) @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
